tank_input_ctrl: RTL and testbench

- Parametrised successor to the single-player Direct key mapper; sits between PS2 and GameLoop in the clk_100mhz domain.
- Turns the PS2 key-event stream into per-player state for NUM_PLAYERS tanks:
  - direction
  - moving flag
  - rate-limited fire strobe
- Tracks held keys; the most recently pressed direction wins, and direction reverts when that key is released.

---
 rtl/tank_input_pkg.sv | 36 +++
 rtl/tank_input_player.sv | 142 ++++++++++++++
 rtl/tank_input_ctrl.sv | 65 ++++++
 tb/tb_tank_input_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_input_pkg.sv
// Shared definitions for tank_input_ctrl: direction codes, fire FSM states
// and the per-player keymap table.
package tank_input_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int MAX_PLAYERS = 4;
    localparam int NUM_KEYS    = 5;
    localparam int KEY_FIRE    = 4;

    typedef enum logic [1:0] {
        FIRE_IDLE,
        FIRE_COOL,
        FIRE_HOLD
    } fire_state_t;

    // Column order matches held-bit order: up, down, left, right, fire.
    localparam logic [7:0] KEYMAP [MAX_PLAYERS][NUM_KEYS] = '{
        '{8'h77, 8'h73, 8'h61, 8'h64, 8'h20},  // w s a d space
        '{8'h69, 8'h6B, 8'h6A, 8'h6C, 8'h75},  // i k j l u
        '{8'h38, 8'h35, 8'h34, 8'h36, 8'h30},  // 8 5 4 6 0
        '{8'h74, 8'h67, 8'h66, 8'h68, 8'h72}   // t g f h r
    };

    // Highest-priority held direction: up > down > left > right.
    function automatic logic [1:0] dir_priority(input logic [3:0] held);
        if (held[0])      return DIR_UP;
        else if (held[1]) return DIR_DOWN;
        else if (held[2]) return DIR_LEFT;
        else              return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/tank_input_player.sv
// One tank's held keys, current direction and rate-limited fire FSM.
// With KEY_TIMEOUT_EN defined, held bits also expire after TIMEOUT cycles.
module tank_input_player
    import tank_input_pkg::*;
#(
    parameter int COOLDOWN = 25_000_000,
    parameter int REPEAT   = 50_000_000
`ifdef KEY_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 100_000_000
`endif
) (
    input  logic                clk_100mhz,
    input  logic                RSTN,
    input  logic [NUM_KEYS-1:0] press,
    input  logic [NUM_KEYS-1:0] brk,
    output logic [2:0]          direct,
    output logic                moving,
    output logic                fire
);

    localparam int CW = $clog2(REPEAT);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT - 1);

    logic [NUM_KEYS-1:0] held_q, held_d, expire, released;
    logic [3:0]          rel_dir;
    logic [1:0]          dir_q, dir_d;
    fire_state_t         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                fire_q, fire_d;

`ifdef KEY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] AGE_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] age_q [NUM_KEYS];
    logic [TW-1:0] age_d [NUM_KEYS];

    // A key's age restarts on every press or typematic repeat.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            age_d[k]  = '0;
            expire[k] = 1'b0;
            if (!press[k] && held_q[k] && !brk[k]) begin
                if (age_q[k] == AGE_LAST) expire[k] = 1'b1;
                else                      age_d[k]  = age_q[k] + TW'(1);
            end
        end
    end

    // NOTE: this counter array is small and feeds control decisions, so every
    // entry is reset rather than left to power up undefined.
    always_ff @(posedge clk_100mhz or negedge RSTN) begin
        if (!RSTN) begin
            for (int k = 0; k < NUM_KEYS; k++) age_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) age_q[k] <= age_d[k];
        end
    end
`else
    assign expire = '0;
`endif

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        held_d   = (held_q & ~brk & ~expire) | press;
        released = held_q & ~held_d;
        rel_dir  = released[3:0];

        dir_d = dir_q;
        if (|press[3:0]) begin
            dir_d = dir_priority(press[3:0]);
        end else if (rel_dir[dir_q] && |held_d[3:0]) begin
            dir_d = dir_priority(held_d[3:0]);
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        unique case (state_q)
            FIRE_IDLE: begin
                if (press[KEY_FIRE]) begin
                    fire_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = FIRE_COOL;
                end
            end
            FIRE_COOL: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == COOL_LAST) begin
                    if (held_d[KEY_FIRE]) begin
                        state_d = FIRE_HOLD;
                    end else begin
                        state_d = FIRE_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            FIRE_HOLD: begin
                if (!held_d[KEY_FIRE]) begin
                    state_d = FIRE_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    fire_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = FIRE_COOL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = FIRE_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_100mhz or negedge RSTN) begin
        if (!RSTN) begin
            held_q  <= '0;
            dir_q   <= DIR_UP;
            state_q <= FIRE_IDLE;
            cnt_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            held_q  <= held_d;
            dir_q   <= dir_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fire_q  <= fire_d;
        end
    end

    assign direct = {1'b0, dir_q};
    assign moving = |held_q[3:0];
    assign fire   = fire_q;

endmodule

// File: rtl/tank_input_ctrl.sv
// PS2 key-event decoder driving NUM_PLAYERS tank_input_player instances.
// Optional held-key staleness timeout is enabled by defining KEY_TIMEOUT_EN.
module tank_input_ctrl
    import tank_input_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int COOLDOWN    = 25_000_000,
    parameter int REPEAT      = 50_000_000,
    parameter int TIMEOUT     = 100_000_000
) (
    input  logic                     clk_100mhz,
    input  logic                     RSTN,
    input  logic                     key_valid,
    input  logic [7:0]               key_code,
    input  logic                     key_break,
    output logic [3*NUM_PLAYERS-1:0] direct,
    output logic [NUM_PLAYERS-1:0]   moving,
    output logic [NUM_PLAYERS-1:0]   fire
);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > MAX_PLAYERS || COOLDOWN < 1 ||
        REPEAT < 2 || REPEAT < COOLDOWN || TIMEOUT < 2) begin : g_bad_cfg
        $error("tank_input_ctrl: unsupported parameter combination");
    end

    logic [NUM_KEYS-1:0] press [NUM_PLAYERS];
    logic [NUM_KEYS-1:0] brk   [NUM_PLAYERS];

    // A code claimed by a lower-indexed player is hidden from higher ones.
    always_comb begin : decode
        logic                taken;
        logic [NUM_KEYS-1:0] hit;
        taken = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            hit = '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                hit[k] = (key_code == KEYMAP[p][k]);
            end
            if (!key_valid || taken) hit = '0;
            press[p] = key_break ? '0 : hit;
            brk[p]   = key_break ? hit : '0;
            taken    = taken | (|hit);
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        tank_input_player #(
            .COOLDOWN (COOLDOWN),
            .REPEAT   (REPEAT)
`ifdef KEY_TIMEOUT_EN
            ,
            .TIMEOUT  (TIMEOUT)
`endif
        ) u_player (
            .clk_100mhz (clk_100mhz),
            .RSTN       (RSTN),
            .press      (press[p]),
            .brk        (brk[p]),
            .direct     (direct[3*p +: 3]),
            .moving     (moving[p]),
            .fire       (fire[p])
        );
    end

endmodule

// File: tb/tb_tank_input_ctrl.sv
// Directed self-checking bench for tank_input_ctrl with short fire timings.
// With KEY_TIMEOUT_EN defined, a second instance exercises the key timeout.
module tb_tank_input_ctrl;

    localparam int NP = 2;
    localparam int CD = 4;
    localparam int RP = 10;

    localparam logic [7:0] K_W = 8'h77, K_S = 8'h73, K_A = 8'h61, K_D = 8'h64;
    localparam logic [7:0] K_SP = 8'h20, K_I = 8'h69, K_K = 8'h6B;
    localparam logic [7:0] K_Z = 8'h7A, K_8 = 8'h38;

    logic            clk_100mhz = 1'b0;
    logic            RSTN       = 1'b1;
    logic            key_valid  = 1'b0;
    logic [7:0]      key_code   = 8'h00;
    logic            key_break  = 1'b0;
    logic [3*NP-1:0] direct;
    logic [NP-1:0]   moving;
    logic [NP-1:0]   fire;

    int checks = 0;
    int errors = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    tank_input_ctrl #(
        .NUM_PLAYERS (NP),
        .COOLDOWN    (CD),
        .REPEAT      (RP),
        .TIMEOUT     (1000)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .RSTN       (RSTN),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_break  (key_break),
        .direct     (direct),
        .moving     (moving),
        .fire       (fire)
    );

`ifdef KEY_TIMEOUT_EN
    logic [3*NP-1:0] direct_t;
    logic [NP-1:0]   moving_t;
    logic [NP-1:0]   fire_t;

    tank_input_ctrl #(
        .NUM_PLAYERS (NP),
        .COOLDOWN    (CD),
        .REPEAT      (RP),
        .TIMEOUT     (20)
    ) dut_to (
        .clk_100mhz (clk_100mhz),
        .RSTN       (RSTN),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_break  (key_break),
        .direct     (direct_t),
        .moving     (moving_t),
        .fire       (fire_t)
    );
`endif

    // Called at a negedge; the event is sampled on the next posedge and the
    // task returns at the following negedge, one cycle after key_valid.
    task automatic send_key(input logic [7:0] code, input logic brk_in);
        key_valid = 1'b1;
        key_code  = code;
        key_break = brk_in;
        @(negedge clk_100mhz);
        key_valid = 1'b0;
        key_break = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        #1 RSTN = 1'b0;
        #1;
        chk("reset_direct", int'(direct), 0);
        chk("reset_moving", int'(moving), 0);
        chk("reset_fire", int'(fire), 0);
        @(negedge clk_100mhz);
        RSTN = 1'b1;
        @(negedge clk_100mhz);
        send_key(K_W, 1'b0);
        chk("w_held_moving", int'(moving[0]), 1);
        #2 RSTN = 1'b0;
        #1;
        @(negedge clk_100mhz);
        RSTN = 1'b1;
        @(negedge clk_100mhz);
        chk("held_discarded_moving", int'(moving[0]), 0);
        send_key(K_A, 1'b0);
        chk("a_press_direct", int'(direct[2:0]), 2);
        chk("a_press_moving", int'(moving[0]), 1);
        send_key(K_A, 1'b1);
        chk("a_break_moving", int'(moving[0]), 0);
        chk("a_break_direct", int'(direct[2:0]), 2);
    endtask

    task automatic test_direction;
        send_key(K_D, 1'b0);
        chk("d_direct", int'(direct[2:0]), 3);
        send_key(K_W, 1'b0);
        chk("d_w_direct", int'(direct[2:0]), 0);
        send_key(K_W, 1'b1);
        chk("w_break_revert", int'(direct[2:0]), 3);
        send_key(K_D, 1'b1);
        chk("d_break_moving", int'(moving[0]), 0);
        chk("d_break_direct", int'(direct[2:0]), 3);
        send_key(K_W, 1'b0);
        send_key(K_S, 1'b0);
        chk("s_direct", int'(direct[2:0]), 1);
        send_key(K_A, 1'b0);
        chk("wsa_direct", int'(direct[2:0]), 2);
        send_key(K_A, 1'b1);
        chk("up_priority", int'(direct[2:0]), 0);
        chk("up_priority_moving", int'(moving[0]), 1);
        send_key(K_S, 1'b1);
        chk("noncurrent_break", int'(direct[2:0]), 0);
        send_key(K_W, 1'b1);
        chk("all_released_moving", int'(moving[0]), 0);
    endtask

    task automatic test_fire;
        int pulses;
        key_valid = 1'b1;
        key_code  = K_SP;
        key_break = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk_100mhz);
            if (i == 1) key_valid = 1'b0;
            chk($sformatf("fire_hold_c%0d", i), int'(fire[0]),
                (i == 1 || i == 11 || i == 21) ? 1 : 0);
        end
        chk("fire_p1_quiet", int'(fire[1]), 0);
        send_key(K_SP, 1'b1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (fire[0]) pulses++;
            @(negedge clk_100mhz);
        end
        chk("fire_after_break", pulses, 0);
        pulses = 0;
        send_key(K_SP, 1'b0);
        if (fire[0]) pulses++;
        send_key(K_SP, 1'b1);
        if (fire[0]) pulses++;
        send_key(K_SP, 1'b0);
        if (fire[0]) pulses++;
        send_key(K_SP, 1'b1);
        if (fire[0]) pulses++;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_100mhz);
            if (fire[0]) pulses++;
        end
        chk("press_break_press_pulses", pulses, 1);
    endtask

    task automatic test_independence;
        send_key(K_K, 1'b0);
        chk("p1_down", int'(direct[5:3]), 1);
        chk("p1_moving", int'(moving[1]), 1);
        send_key(K_I, 1'b0);
        send_key(K_A, 1'b0);
        chk("p1_up", int'(direct[5:3]), 0);
        chk("p0_left", int'(direct[2:0]), 2);
        chk("both_moving", int'(moving), 3);
        send_key(K_Z, 1'b0);
        chk("unmapped_z_direct", int'(direct), 6'b000_010);
        chk("unmapped_z_moving", int'(moving), 3);
        send_key(K_8, 1'b0);
        chk("absent_player_direct", int'(direct), 6'b000_010);
        chk("absent_player_fire", int'(fire), 0);
        send_key(K_I, 1'b1);
        chk("p1_revert_down", int'(direct[5:3]), 1);
        send_key(K_K, 1'b1);
        chk("p1_released", int'(moving[1]), 0);
        send_key(K_A, 1'b1);
        chk("none_moving", int'(moving), 0);
    endtask

    task automatic test_reset_mid_hold;
        int pulses;
        send_key(K_D, 1'b0);
        send_key(K_SP, 1'b0);
        chk("mid_hold_first_pulse", int'(fire[0]), 1);
        repeat (10) @(negedge clk_100mhz);
        chk("mid_hold_repeat_pulse", int'(fire[0]), 1);
        #2 RSTN = 1'b0;
        #1;
        chk("async_rst_fire", int'(fire), 0);
        chk("async_rst_moving", int'(moving), 0);
        chk("async_rst_direct", int'(direct), 0);
        @(negedge clk_100mhz);
        RSTN = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_100mhz);
            if (fire[0]) pulses++;
        end
        chk("no_pulse_after_reset", pulses, 0);
        chk("no_moving_after_reset", int'(moving[0]), 0);
        send_key(K_SP, 1'b0);
        chk("new_press_pulse", int'(fire[0]), 1);
        send_key(K_SP, 1'b1);
        repeat (10) @(negedge clk_100mhz);
    endtask

    task automatic test_hold_persists;
        send_key(K_D, 1'b0);
        repeat (40) @(negedge clk_100mhz);
        chk("hold_persists_moving", int'(moving[0]), 1);
        chk("hold_persists_direct", int'(direct[2:0]), 3);
        send_key(K_D, 1'b1);
        chk("hold_released", int'(moving[0]), 0);
    endtask

`ifdef KEY_TIMEOUT_EN
    task automatic test_timeout;
        #2 RSTN = 1'b0;
        #1;
        @(negedge clk_100mhz);
        RSTN = 1'b1;
        @(negedge clk_100mhz);
        send_key(K_D, 1'b0);
        chk("to_pressed", int'(moving_t[0]), 1);
        repeat (19) @(negedge clk_100mhz);
        chk("to_before_expiry", int'(moving_t[0]), 1);
        @(negedge clk_100mhz);
        chk("to_expired", int'(moving_t[0]), 0);
        chk("to_expired_direct", int'(direct_t[2:0]), 3);
        send_key(K_D, 1'b1);
        send_key(K_D, 1'b0);
        repeat (14) @(negedge clk_100mhz);
        send_key(K_D, 1'b0);
        repeat (19) @(negedge clk_100mhz);
        chk("to_refresh_held", int'(moving_t[0]), 1);
        @(negedge clk_100mhz);
        chk("to_refresh_expired", int'(moving_t[0]), 0);
        send_key(K_D, 1'b1);
    endtask
`endif

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_direction();
        test_fire();
        test_independence();
        test_reset_mid_hold();
        test_hold_persists();
`ifdef KEY_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
